// File: rtl/prio_fifo_drain_if.sv
// Handshake bundle for prio_fifo_drain: upstream FIFO read side,
// shared timebase, downstream valid/ready side and drop reporting.
interface prio_fifo_drain_if #(
  parameter int DL_W = 10
);
  localparam int W = DL_W + 11;

  logic            fifo_empty;
  logic            fifo_re;
  logic [W-1:0]    fifo_dout;
  logic [DL_W-1:0] now_time;
  logic            out_valid;
  logic            out_ready;
  logic [10:0]     out_desc;
  logic [DL_W-1:0] out_deadline;
  logic            drop_pulse;
  logic [15:0]     drop_cnt;

  modport slave (
    input  fifo_empty,
    input  fifo_dout,
    input  now_time,
    input  out_ready,
    output fifo_re,
    output out_valid,
    output out_desc,
    output out_deadline,
    output drop_pulse,
    output drop_cnt
  );

  modport master (
    output fifo_empty,
    output fifo_dout,
    output now_time,
    output out_ready,
    input  fifo_re,
    input  out_valid,
    input  out_desc,
    input  out_deadline,
    input  drop_pulse,
    input  drop_cnt
  );
endinterface

// File: rtl/prio_fifo_drain.sv
// Drains a latency-RD_LAT priority FIFO into a 2-entry skid buffer.
// Define PRIO_DRAIN_DROP_EXPIRED_EN to discard expired words at capture.
module prio_fifo_drain #(
  parameter int RD_LAT = 1,
  parameter int DL_W   = 10
) (
  input logic             clk,
  input logic             rst,
  prio_fifo_drain_if.slave bus
);
  localparam int DESC_W = 11;
  localparam int W      = DL_W + DESC_W;

  logic [RD_LAT-1:0] tag_q;
  logic [RD_LAT-1:0] tag_d;
  logic [W-1:0]      ent0_q;
  logic [W-1:0]      ent0_d;
  logic [W-1:0]      ent1_q;
  logic [W-1:0]      ent1_d;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;

  logic       valid;
  logic       xfer;
  logic       cap;
  logic       drop;
  logic       push;
  logic       re;
  logic [2:0] infl;
  logic [2:0] load;

  assign valid = (cnt_q != 2'd0);
  assign xfer  = valid && bus.out_ready;
  assign cap   = tag_q[RD_LAT-1];

`ifdef PRIO_DRAIN_DROP_EXPIRED_EN
  logic [DL_W-1:0] age;
  logic            expired;
  logic            drop_pulse_q;
  logic            drop_pulse_d;
  logic [15:0]     drop_cnt_q;
  logic [15:0]     drop_cnt_d;

  // Age wraps with the timebase; the upper half of the range is "not yet due".
  assign age     = bus.now_time - bus.fifo_dout[W-1:DESC_W];
  assign expired = (age != '0) && !age[DL_W-1];
  assign drop    = cap && expired;

  always_comb begin
    drop_pulse_d = drop;
    drop_cnt_d   = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= 16'd0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_cnt   = drop_cnt_q;
`else
  assign drop           = 1'b0;
  assign bus.drop_pulse = 1'b0;
  assign bus.drop_cnt   = 16'd0;
`endif

  assign push = cap && !drop;

  always_comb begin
    infl = 3'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + 3'(tag_q[i]);
    end
  end

  // Credits: stored after this cycle's transfer plus reads still in flight.
  assign load = {1'b0, cnt_q} - {2'b0, xfer}
              + infl - {2'b0, drop};
  assign re   = !rst && !bus.fifo_empty && (load < 3'd2);

  always_comb begin
    tag_d    = '0;
    tag_d[0] = re;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({xfer, push})
      2'b10: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd0) begin
          ent0_d = bus.fifo_dout;
        end else begin
          ent1_d = bus.fifo_dout;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = bus.fifo_dout;
        end else begin
          ent0_d = ent1_q;
          ent1_d = bus.fifo_dout;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= '0;
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      tag_q  <= tag_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.fifo_re      = re;
  assign bus.out_valid    = valid;
  assign bus.out_desc     = ent0_q[DESC_W-1:0];
  assign bus.out_deadline = ent0_q[W-1:DESC_W];
endmodule

// File: tb/tb_prio_fifo_drain.sv
// Scoreboard bench: two drains (read latency 1 and 3) fed from the same
// word stream, each checked against a queue-based model of the rules.
module tb_prio_fifo_drain;
  localparam int DL_W = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] now_time = 10'd0;
  bit         now_hold = 1'b0;
  logic       out_ready = 1'b0;
  int         total = 0;
  int         bad = 0;

  logic [20:0] src_q [2][$];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int ln,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane%0d got=%0h want=%0h t=%0t",
               nm, ln, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    prio_fifo_drain_if #(.DL_W(DL_W)) bus ();

    prio_fifo_drain #(.RD_LAT(LAT), .DL_W(DL_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign bus.now_time  = now_time;
    assign bus.out_ready = out_ready;

    logic [20:0] dpipe [LAT];
    logic [20:0] rd_word;
    bit          re_l;
    int          cyc_l;
    int          fl_cap [$];
    logic [20:0] fl_w [$];
    logic [20:0] exp_q [$];
    int          exp_drops;
    bit          drop_prev;
    bit          rst_prev;
    bit          hold_prev;
    logic [20:0] head_prev;
    int          re_cnt;
    int          xfer_cnt;

    initial begin
      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = '0;
      for (int i = 0; i < LAT; i++) dpipe[i] = '0;
      rd_word = '0; re_l = 0; cyc_l = 0; exp_drops = 0;
      drop_prev = 0; rst_prev = 1; hold_prev = 0; head_prev = '0;
      re_cnt = 0; xfer_cnt = 0;
    end

    // Upstream FIFO: read data appears LAT cycles after the strobe.
    always @(posedge clk) begin
      #1;
      for (int i = LAT - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
      dpipe[0] = re_l ? rd_word : 21'($urandom);
      bus.fifo_dout  = dpipe[LAT-1];
      bus.fifo_empty = (src_q[g].size() == 0);
    end

    always @(negedge clk) begin
      bit          xfer;
      bit          cap_now;
      bit          drop_now;
      bit          exp_re;
      logic [20:0] cw;
      logic [20:0] head;
      logic [9:0]  age;
      head = {bus.out_deadline, bus.out_desc};
      if (rst) begin
        chk("re_in_reset", g, bus.fifo_re, 0);
        fl_cap.delete(); fl_w.delete(); exp_q.delete();
        re_l = 0; exp_drops = 0; drop_prev = 0;
        rst_prev = 1; hold_prev = 0;
      end else begin
        if (rst_prev) begin
          chk("rst_valid", g, bus.out_valid, 0);
          chk("rst_desc", g, bus.out_desc, 0);
          chk("rst_deadline", g, bus.out_deadline, 0);
        end
        chk("valid", g, bus.out_valid, exp_q.size() != 0);
        chk("drop_cnt", g, bus.drop_cnt, exp_drops);
        chk("drop_pulse", g, bus.drop_pulse, drop_prev);
        if (hold_prev) begin
          chk("hold_valid", g, bus.out_valid, 1);
          chk("hold_data", g, head, head_prev);
        end
        xfer = bus.out_valid && out_ready;
        if (xfer) begin
          xfer_cnt++;
          if (exp_q.size() != 0) chk("data", g, head, exp_q.pop_front());
        end
        hold_prev = bus.out_valid && !out_ready;
        head_prev = head;
        cap_now = 0; drop_now = 0; cw = '0;
        if (fl_cap.size() != 0 && fl_cap[0] == cyc_l) begin
          cap_now = 1;
          cw = fl_w[0];
`ifdef PRIO_DRAIN_DROP_EXPIRED_EN
          age = now_time - cw[20:11];
          drop_now = (age >= 10'd1) && (age <= 10'd511);
`else
          age = 10'd0;
`endif
        end
        exp_re = !bus.fifo_empty &&
                 (exp_q.size() + fl_cap.size() - int'(drop_now) < 2);
        chk("fifo_re", g, bus.fifo_re, exp_re);
        if (cap_now) begin
          void'(fl_cap.pop_front());
          void'(fl_w.pop_front());
          if (drop_now) begin
            if (exp_drops < 65535) exp_drops++;
          end else begin
            exp_q.push_back(cw);
          end
        end
        re_l = 0;
        if (bus.fifo_re) begin
          re_cnt++;
          if (src_q[g].size() != 0) begin
            rd_word = src_q[g].pop_front();
            fl_cap.push_back(cyc_l + LAT);
            fl_w.push_back(rd_word);
            re_l = 1;
          end
        end
        drop_prev = drop_now;
        rst_prev  = 0;
      end
      cyc_l++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (!now_hold) now_time = now_time + 10'd1;
    end
  endtask

  task automatic push_word(input logic [9:0] dl, input logic [10:0] ds);
    src_q[0].push_back({dl, ds});
    src_q[1].push_back({dl, ds});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q[0].delete();
    src_q[1].delete();
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int r0, r1, x0, x1, k;
    bit done;

    // Three-word burst at latency 1.
    now_hold = 1; now_time = 10'd100;
    tick(2);
    do_reset();
    out_ready = 1;
    r0 = lane[0].re_cnt; x0 = lane[0].xfer_cnt;
    for (int i = 0; i < 3; i++) push_word(10'd100, 11'(16 + i));
    tick(12);
    chk("burst_reads", 0, lane[0].re_cnt - r0, 3);
    chk("burst_xfers", 0, lane[0].xfer_cnt - x0, 3);

    // Back-pressure: only two reads while stalled.
    do_reset();
    out_ready = 0;
    r0 = lane[0].re_cnt; r1 = lane[1].re_cnt;
    x0 = lane[0].xfer_cnt; x1 = lane[1].xfer_cnt;
    for (int i = 0; i < 5; i++) push_word(10'd100, 11'(40 + i));
    tick(12);
    chk("stall_reads", 0, lane[0].re_cnt - r0, 2);
    chk("stall_reads", 1, lane[1].re_cnt - r1, 2);
    out_ready = 1;
    tick(16);
    chk("stall_drain", 0, lane[0].xfer_cnt - x0, 5);
    chk("stall_drain", 1, lane[1].xfer_cnt - x1, 5);

    // Expiry boundary at now=10.
    do_reset();
    now_time = 10'd10;
    x0 = lane[0].xfer_cnt;
    push_word(10'd9, 11'h055);
    push_word(10'd10, 11'h0AA);
    tick(12);
`ifdef PRIO_DRAIN_DROP_EXPIRED_EN
    chk("exp_cnt", 0, lane[0].bus.drop_cnt, 1);
    chk("exp_fwd", 0, lane[0].xfer_cnt - x0, 1);
`else
    chk("exp_cnt", 0, lane[0].bus.drop_cnt, 0);
    chk("exp_fwd", 0, lane[0].xfer_cnt - x0, 2);
`endif

    // Wrap-around of the timebase.
    do_reset();
    now_time = 10'd5;
    x1 = lane[1].xfer_cnt;
    push_word(10'd1020, 11'h123);
    tick(10);
    now_time = 10'd1020;
    push_word(10'd5, 11'h321);
    tick(10);
`ifdef PRIO_DRAIN_DROP_EXPIRED_EN
    chk("wrap_cnt", 1, lane[1].bus.drop_cnt, 1);
    chk("wrap_fwd", 1, lane[1].xfer_cnt - x1, 1);
`else
    chk("wrap_cnt", 1, lane[1].bus.drop_cnt, 0);
    chk("wrap_fwd", 1, lane[1].xfer_cnt - x1, 2);
`endif

    // Reset with two reads in flight at latency 3.
    do_reset();
    now_time = 10'd200;
    push_word(10'd200, 11'h011);
    push_word(10'd200, 11'h022);
    k = 0;
    while (lane[1].fl_cap.size() < 2 && k < 20) begin
      tick();
      k++;
    end
    chk("inflight", 1, lane[1].fl_cap.size(), 2);
    x1 = lane[1].xfer_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("flush_valid", 1, lane[1].bus.out_valid, 0);
    tick(8);
    chk("flush_xfers", 1, lane[1].xfer_cnt - x1, 0);

    // Random traffic with a free-running timebase.
    do_reset();
    now_hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 9) < 4)
        push_word(10'($urandom), 11'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    out_ready = 1;
    done = 0;
    k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
             (lane[0].fl_cap.size() == 0) && (lane[1].fl_cap.size() == 0) &&
             (lane[0].exp_q.size() == 0) && (lane[1].exp_q.size() == 0);
    end
    chk("drain_done", 0, done, 1);
    tick(2);
    chk("drain_valid", 0, lane[0].bus.out_valid, 0);
    chk("drain_valid", 1, lane[1].bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prio_fifo_drain.md
PRIO_FIFO_DRAIN -- requirements
Module: prio_fifo_drain

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from fifo_re asserted to fifo_dout valid; legal range 1..4.
REQ-002 Parameter DL_W, default 10: deadline field width; word layout is [20:11] deadline, [10:0] descriptor.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 fifo_empty  input  1  empty flag of the upstream 21-bit x 32 priority FIFO.
REQ-006 fifo_re  output  1  read strobe to the upstream FIFO.
REQ-007 fifo_dout  input  21  upstream FIFO read data, valid RD_LAT cycles after fifo_re.
REQ-008 now_time  input  10  shared free-running timebase, wraps modulo 1024.
REQ-009 out_valid  output  1  output entry present.
REQ-010 out_ready  input  1  downstream accepts; transfer when out_valid and out_ready both high.
REQ-011 out_desc  output  11  descriptor of the head entry.
REQ-012 out_deadline  output  10  deadline of the head entry.
REQ-013 drop_pulse  output  1  one-cycle pulse per discarded expired entry.
REQ-014 drop_cnt  output  16  saturating count of discarded entries.

Function
REQ-015 Output storage is a 2-entry FIFO (skid buffer); out_desc and out_deadline always show the oldest stored entry.
REQ-016 In-flight tracking: RD_LAT-deep shift register of read tags; a tag set at the fifo_re cycle captures fifo_dout exactly RD_LAT cycles later.
REQ-017 fifo_re is asserted in a cycle only when fifo_empty=0 and (stored + in-flight) < 2, counting stored after any transfer in the same cycle.
REQ-018 fifo_re is never asserted while fifo_empty=1, including in the cycle reset deasserts.
REQ-019 Zero-bubble throughput: with RD_LAT=1, FIFO non-empty and out_ready held high, one transfer per cycle after a 2-cycle startup.
REQ-020 First-word latency: fifo_empty falling to out_valid rising is RD_LAT+1 cycles.
REQ-021 Capture and transfer in the same cycle with 2 entries stored: the transfer frees a slot first, so no overflow; REQ-017 guarantees no capture into a full buffer.
REQ-022 out_valid, out_desc and out_deadline hold stable while out_valid=1 and out_ready=0.
REQ-023 Expiry test at capture, mod-1024 arithmetic: d = (now_time - deadline) mod 1024; expired iff 1 <= d <= 511; d = 0 (deadline equal to now) is not expired.
REQ-024 An entry accepted into storage is never re-tested, and no later drop applies to it.
REQ-025 Ordering: entries leave in FIFO read order, except for discarded entries.

Reset
REQ-026 Reset clears the buffer, the in-flight tags and the credit count.
REQ-027 Output values during and after reset: out_valid=0, fifo_re=0, drop_pulse=0, drop_cnt=0, out_desc=0, out_deadline=0.
REQ-028 Reset mid-operation discards in-flight reads; their fifo_dout words are ignored.
REQ-029 Reset has priority over all other events in the same cycle.

Configuration
REQ-030 Macro PRIO_DRAIN_DROP_EXPIRED_EN, when defined: expired entries are discarded at capture, pulse drop_pulse, increment drop_cnt (saturating at 16'hFFFF), and release their credit in the capture cycle.
REQ-031 When PRIO_DRAIN_DROP_EXPIRED_EN is not defined: all entries are forwarded, and drop_pulse and drop_cnt are tied to 0.

Verification
REQ-032 Reset then FIFO preloaded with 3 words, out_ready=1, RD_LAT=1 -> fifo_re high 3 consecutive cycles; out_valid high 3 cycles starting 2 cycles after first fifo_re; data in order.
REQ-033 out_ready=0 with 5 words queued -> exactly 2 fifo_re pulses, out_valid held with the first word stable; out_ready=1 -> remaining 3 drain in order with no loss or duplication.
REQ-034 Macro defined, now_time=10, word deadline=9 -> discarded, drop_pulse=1 for one cycle, drop_cnt=1; deadline=10 -> forwarded.
REQ-035 Wrap-around, macro defined: now_time=5, deadline=1020 -> expired (d=9); now_time=1020, deadline=5 -> forwarded (d=1015).
REQ-036 rst asserted with 2 reads in flight at RD_LAT=3 -> next cycle out_valid=0; the arriving fifo_dout words never appear on the output.
REQ-037 Macro undefined, expired word -> forwarded, drop_cnt stays 0.
